stroke_rasterizer: RTL and testbench

- Converts the stream of cursor samples into a stream of single-pixel canvas writes.
- Samples come from local user input or from the decoded link word (x, y, color, stroke width), one per frame.
- Interpolates a Bresenham line from the previous sample to the new one and stamps a square brush at every line point.
- Sits directly upstream of the frame_buffer write port, replacing its per-frame single-point stamping. Canvas is the scaled 320x180 grid.

---
 rtl/stroke_rasterizer.sv | 204 ++++++++++++++++++++
 tb/tb_stroke_rasterizer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stroke_rasterizer.sv
// Turns cursor samples into single-pixel canvas writes: Bresenham line from the previous
// sample, square brush stamped at every new line point. Define STROKE_ROUND_BRUSH_EN for round tips.
module stroke_rasterizer #(
    parameter int CANVAS_W = 320,
    parameter int CANVAS_H = 180,
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int COLOR_W  = 4,
    parameter int SW_W     = 3
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               pt_valid_in,
    output logic               pt_ready_out,
    input  logic [X_W-1:0]     pt_x_in,
    input  logic [Y_W-1:0]     pt_y_in,
    input  logic [COLOR_W-1:0] pt_color_in,
    input  logic [SW_W-1:0]    pt_sw_in,
    input  logic               pt_pen_down_in,
    output logic               wr_valid_out,
    input  logic               wr_ready_in,
    output logic [X_W-1:0]     wr_x_out,
    output logic [Y_W-1:0]     wr_y_out,
    output logic [COLOR_W-1:0] wr_color_out,
    output logic               busy_out,
    output logic               stroke_done_out
);
    localparam int XS = X_W + 2;
    localparam int YS = Y_W + 2;
    localparam int EW = X_W + 2;
    localparam logic signed [XS-1:0] X_MAX = XS'(CANVAS_W - 1);
    localparam logic signed [YS-1:0] Y_MAX = YS'(CANVAS_H - 1);
    localparam logic signed [XS-1:0] ONE_X = XS'(1);
    localparam logic signed [YS-1:0] ONE_Y = YS'(1);

    typedef enum logic [1:0] {IDLE, LINE, BRUSH, DONE} state_t;
    state_t state_q, state_d;

    logic                     have_prev_q, have_prev_d;
    logic [X_W-1:0]           x0_q, x0_d, x1_q, x1_d;
    logic [Y_W-1:0]           y0_q, y0_d, y1_q, y1_d;
    logic [COLOR_W-1:0]       color_q, color_d;
    logic [SW_W-1:0]          r_q, r_d;
    logic                     pen_q, pen_d;
    logic                     sx_q, sx_d, sy_q, sy_d;
    logic signed [XS-1:0]     cx_q, cx_d, bx_q, bx_d;
    logic signed [YS-1:0]     cy_q, cy_d, by_q, by_d;
    logic signed [EW-1:0]     err_q, err_d, dx_q, dx_d, dy_q, dy_d;

    logic signed [XS-1:0] rx, rx_new, nx;
    logic signed [YS-1:0] ry, ry_new, ny;
    logic signed [EW-1:0] xdiff, ydiff, adx, ady, nerr;
    logic signed [EW:0]   e2, dx_ext, dy_ext;
    logic step_x, step_y, stamp_only, in_bounds, brush_on;
    logic pix_valid, pix_adv, row_end, col_end, scan_end, at_target;

    assign rx     = XS'(r_q);
    assign ry     = YS'(r_q);
    assign rx_new = XS'(pt_sw_in);
    assign ry_new = YS'(pt_sw_in);

    assign stamp_only = !have_prev_q || (pt_x_in == x0_q && pt_y_in == y0_q);
    assign xdiff = $signed(EW'(pt_x_in)) - $signed(EW'(x0_q));
    assign ydiff = $signed(EW'(pt_y_in)) - $signed(EW'(y0_q));
    assign adx   = xdiff[EW-1] ? -xdiff : xdiff;
    assign ady   = ydiff[EW-1] ? -ydiff : ydiff;

    // Bresenham step; e2 needs one extra bit over err
    assign e2     = {err_q, 1'b0};
    assign dx_ext = {dx_q[EW-1], dx_q};
    assign dy_ext = {dy_q[EW-1], dy_q};
    assign step_x = (e2 >= dy_ext);
    assign step_y = (e2 <= dx_ext);
    assign nx   = step_x ? (sx_q ? cx_q - ONE_X : cx_q + ONE_X) : cx_q;
    assign ny   = step_y ? (sy_q ? cy_q - ONE_Y : cy_q + ONE_Y) : cy_q;
    assign nerr = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);

    assign in_bounds = (bx_q >= 0) && (bx_q <= X_MAX) && (by_q >= 0) && (by_q <= Y_MAX);

`ifdef STROKE_ROUND_BRUSH_EN
    logic signed [4:0] ox, oy;
    logic signed [9:0] ox_sq, oy_sq, rr, lim;
    assign ox    = 5'(bx_q - cx_q);
    assign oy    = 5'(by_q - cy_q);
    assign ox_sq = ox * ox;
    assign oy_sq = oy * oy;
    assign rr    = 10'(r_q) * 10'(r_q);
    // r = 1 uses r*r so the corners drop; larger radii use r*r + r for a fuller disc
    assign lim      = (r_q <= SW_W'(1)) ? rr : rr + 10'(r_q);
    assign brush_on = (ox_sq + oy_sq) <= lim;
`else
    assign brush_on = 1'b1;
`endif

    assign pix_valid = (state_q == BRUSH) && in_bounds && brush_on;
    assign pix_adv   = !pix_valid || wr_ready_in;
    assign row_end   = (bx_q == cx_q + rx);
    assign col_end   = (by_q == cy_q + ry);
    assign scan_end  = (state_q == BRUSH) && pix_adv && row_end && col_end;
    assign at_target = (cx_q == {2'b00, x1_q}) && (cy_q == {2'b00, y1_q});

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pt_valid_in) begin
                    if (!pt_pen_down_in) state_d = DONE;
                    else if (stamp_only) state_d = BRUSH;
                    else                 state_d = LINE;
                end
            end
            LINE:  state_d = BRUSH;
            BRUSH: if (scan_end) state_d = at_target ? DONE : LINE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        have_prev_d = have_prev_q;
        x0_d = x0_q;  y0_d = y0_q;  x1_d = x1_q;  y1_d = y1_q;
        color_d = color_q;  r_d = r_q;  pen_d = pen_q;
        sx_d = sx_q;  sy_d = sy_q;
        cx_d = cx_q;  cy_d = cy_q;  bx_d = bx_q;  by_d = by_q;
        err_d = err_q;  dx_d = dx_q;  dy_d = dy_q;
        case (state_q)
            IDLE: begin
                if (pt_valid_in) begin
                    x1_d = pt_x_in;  y1_d = pt_y_in;
                    color_d = pt_color_in;  r_d = pt_sw_in;  pen_d = pt_pen_down_in;
                    if (!pt_pen_down_in) begin
                        have_prev_d = 1'b0;
                    end else if (stamp_only) begin
                        cx_d = XS'(pt_x_in);
                        cy_d = YS'(pt_y_in);
                        bx_d = XS'(pt_x_in) - rx_new;
                        by_d = YS'(pt_y_in) - ry_new;
                    end else begin
                        cx_d  = XS'(x0_q);
                        cy_d  = YS'(y0_q);
                        dx_d  = adx;
                        dy_d  = -ady;
                        err_d = adx - ady;
                        sx_d  = (pt_x_in < x0_q);
                        sy_d  = (pt_y_in < y0_q);
                    end
                end
            end
            LINE: begin
                cx_d = nx;  cy_d = ny;  err_d = nerr;
                bx_d = nx - rx;
                by_d = ny - ry;
            end
            BRUSH: begin
                if (pix_adv) begin
                    if (row_end) begin
                        bx_d = cx_q - rx;
                        by_d = by_q + ONE_Y;
                    end else begin
                        bx_d = bx_q + ONE_X;
                    end
                end
            end
            DONE: begin
                x0_d = x1_q;  y0_d = y1_q;
                have_prev_d = pen_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            have_prev_q <= 1'b0;
            x0_q <= '0;  y0_q <= '0;  x1_q <= '0;  y1_q <= '0;
            color_q <= '0;  r_q <= '0;  pen_q <= 1'b0;
            sx_q <= 1'b0;  sy_q <= 1'b0;
            cx_q <= '0;  cy_q <= '0;  bx_q <= '0;  by_q <= '0;
            err_q <= '0;  dx_q <= '0;  dy_q <= '0;
        end else begin
            have_prev_q <= have_prev_d;
            x0_q <= x0_d;  y0_q <= y0_d;  x1_q <= x1_d;  y1_q <= y1_d;
            color_q <= color_d;  r_q <= r_d;  pen_q <= pen_d;
            sx_q <= sx_d;  sy_q <= sy_d;
            cx_q <= cx_d;  cy_q <= cy_d;  bx_q <= bx_d;  by_q <= by_d;
            err_q <= err_d;  dx_q <= dx_d;  dy_q <= dy_d;
        end
    end

    always_comb begin
        pt_ready_out    = (state_q == IDLE);
        busy_out        = (state_q != IDLE);
        stroke_done_out = (state_q == DONE);
        wr_valid_out    = pix_valid;
        wr_x_out        = bx_q[X_W-1:0];
        wr_y_out        = by_q[Y_W-1:0];
        wr_color_out    = color_q;
    end
endmodule

// File: tb/tb_stroke_rasterizer.sv
// Directed bench for stroke_rasterizer: each scenario task drives samples and checks writes inline.
module tb_stroke_rasterizer;
    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       pt_valid_in;
    logic       pt_ready_out;
    logic [9:0] pt_x_in;
    logic [8:0] pt_y_in;
    logic [3:0] pt_color_in;
    logic [2:0] pt_sw_in;
    logic       pt_pen_down_in;
    logic       wr_valid_out;
    logic       wr_ready_in;
    logic [9:0] wr_x_out;
    logic [8:0] wr_y_out;
    logic [3:0] wr_color_out;
    logic       busy_out;
    logic       stroke_done_out;

    int n_cmp = 0;
    int n_err = 0;
    int got_x[$];
    int got_y[$];
    int got_c[$];

    stroke_rasterizer dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .pt_valid_in(pt_valid_in), .pt_ready_out(pt_ready_out),
        .pt_x_in(pt_x_in), .pt_y_in(pt_y_in), .pt_color_in(pt_color_in),
        .pt_sw_in(pt_sw_in), .pt_pen_down_in(pt_pen_down_in),
        .wr_valid_out(wr_valid_out), .wr_ready_in(wr_ready_in),
        .wr_x_out(wr_x_out), .wr_y_out(wr_y_out), .wr_color_out(wr_color_out),
        .busy_out(busy_out), .stroke_done_out(stroke_done_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic do_reset();
        rst_in = 1'b0;
        pt_valid_in = 1'b0;
        wr_ready_in = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
    endtask

    // Offers one sample, then records every accepted write until stroke_done; ends one cycle later.
    task automatic run_sample(input int x, input int y, input int c, input int r, input int pen);
        int w;
        bit done_seen;
        got_x.delete(); got_y.delete(); got_c.delete();
        pt_x_in = 10'(x); pt_y_in = 9'(y); pt_color_in = 4'(c);
        pt_sw_in = 3'(r); pt_pen_down_in = pen[0];
        pt_valid_in = 1'b1;
        w = 0;
        while (!pt_ready_out && w < 200) begin @(negedge clk_in); w++; end
        @(negedge clk_in);
        pt_valid_in = 1'b0;
        done_seen = 1'b0;
        for (int cyc = 0; cyc < 1000 && !done_seen; cyc++) begin
            if (wr_valid_out && wr_ready_in) begin
                got_x.push_back(int'(wr_x_out));
                got_y.push_back(int'(wr_y_out));
                got_c.push_back(int'(wr_color_out));
                $display("  write (%0d,%0d) color %0d", wr_x_out, wr_y_out, wr_color_out);
            end
            if (stroke_done_out) done_seen = 1'b1;
            else @(negedge clk_in);
        end
        n_cmp++;
        if (!done_seen) begin
            n_err++;
            $display("FAIL stroke_done_timeout sample (%0d,%0d): got no done pulse, required one", x, y);
        end else begin
            @(negedge clk_in);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        pt_valid_in = 1'b0;
        wr_ready_in = 1'b1;
        pt_x_in = '0; pt_y_in = '0; pt_color_in = '0; pt_sw_in = '0; pt_pen_down_in = 1'b0;
        repeat (2) @(negedge clk_in);
        n_cmp++;
        if ({wr_valid_out, stroke_done_out, busy_out, pt_ready_out} !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_ctrl: got valid/done/busy/ready=%b%b%b%b, required 0001",
                     wr_valid_out, stroke_done_out, busy_out, pt_ready_out);
        end
        n_cmp++;
        if (wr_x_out !== 10'd0 || wr_y_out !== 9'd0 || wr_color_out !== 4'd0) begin
            n_err++;
            $display("FAIL reset_data: got (%0d,%0d,%0d), required (0,0,0)", wr_x_out, wr_y_out, wr_color_out);
        end
        rst_in = 1'b1;
        @(negedge clk_in);
        $display("reset checked");
    endtask

    task automatic test_single_stamp();
        do_reset();
        run_sample(10, 20, 5, 0, 1);
        n_cmp++;
        if (got_x.size() != 1 || got_x[0] !== 10 || got_y[0] !== 20 || got_c[0] !== 5) begin
            n_err++;
            $display("FAIL single_stamp: got %0d writes first (%0d,%0d,%0d), required 1 write (10,20,5)",
                     got_x.size(), got_x.size() ? got_x[0] : -1, got_y.size() ? got_y[0] : -1,
                     got_c.size() ? got_c[0] : -1);
        end
        n_cmp++;
        if (busy_out !== 1'b0 || pt_ready_out !== 1'b1) begin
            n_err++;
            $display("FAIL single_idle: got busy=%b ready=%b, required busy=0 ready=1", busy_out, pt_ready_out);
        end
    endtask

    task automatic test_line();
        int ex_x[5];
        int ex_y[5];
        ex_x = '{1, 2, 3, 4, 5};
        ex_y = '{0, 1, 1, 2, 2};
        do_reset();
        run_sample(0, 0, 7, 0, 1);
        n_cmp++;
        if (got_x.size() != 1 || got_x[0] !== 0 || got_y[0] !== 0) begin
            n_err++;
            $display("FAIL line_origin: got %0d writes, required 1 write at (0,0)", got_x.size());
        end
        run_sample(5, 2, 7, 0, 1);
        n_cmp++;
        if (got_x.size() != 5) begin
            n_err++;
            $display("FAIL line_count: got %0d writes, required 5", got_x.size());
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (i >= got_x.size() || got_x[i] !== ex_x[i] || got_y[i] !== ex_y[i] || got_c[i] !== 7) begin
                n_err++;
                $display("FAIL line_pt%0d: got (%0d,%0d,%0d), required (%0d,%0d,7)", i,
                         i < got_x.size() ? got_x[i] : -1, i < got_y.size() ? got_y[i] : -1,
                         i < got_c.size() ? got_c[i] : -1, ex_x[i], ex_y[i]);
            end
        end
    endtask

    task automatic test_clip();
        int ex_x[4];
        int ex_y[4];
        do_reset();
        run_sample(0, 0, 1, 1, 1);
        ex_x = '{0, 1, 0, 1};
        ex_y = '{0, 0, 1, 1};
        n_cmp++;
        if (got_x.size() != 4) begin
            n_err++;
            $display("FAIL clip_lo_count: got %0d writes, required 4", got_x.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= got_x.size() || got_x[i] !== ex_x[i] || got_y[i] !== ex_y[i]) begin
                n_err++;
                $display("FAIL clip_lo_pt%0d: got (%0d,%0d), required (%0d,%0d)", i,
                         i < got_x.size() ? got_x[i] : -1, i < got_y.size() ? got_y[i] : -1, ex_x[i], ex_y[i]);
            end
        end
        do_reset();
        run_sample(319, 179, 2, 1, 1);
        ex_x = '{318, 319, 318, 319};
        ex_y = '{178, 178, 179, 179};
        n_cmp++;
        if (got_x.size() != 4) begin
            n_err++;
            $display("FAIL clip_hi_count: got %0d writes, required 4", got_x.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= got_x.size() || got_x[i] !== ex_x[i] || got_y[i] !== ex_y[i]) begin
                n_err++;
                $display("FAIL clip_hi_pt%0d: got (%0d,%0d), required (%0d,%0d)", i,
                         i < got_x.size() ? got_x[i] : -1, i < got_y.size() ? got_y[i] : -1, ex_x[i], ex_y[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        wr_ready_in = 1'b0;
        pt_x_in = 10'd7; pt_y_in = 9'd8; pt_color_in = 4'd3; pt_sw_in = 3'd0; pt_pen_down_in = 1'b1;
        pt_valid_in = 1'b1;
        @(negedge clk_in);
        pt_valid_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (wr_valid_out !== 1'b1 || wr_x_out !== 10'd7 || wr_y_out !== 9'd8 ||
                wr_color_out !== 4'd3 || pt_ready_out !== 1'b0) begin
                n_err++;
                $display("FAIL stall_cyc%0d: got valid=%b (%0d,%0d,%0d) ready=%b, required valid=1 (7,8,3) ready=0",
                         i, wr_valid_out, wr_x_out, wr_y_out, wr_color_out, pt_ready_out);
            end
            @(negedge clk_in);
        end
        wr_ready_in = 1'b1;
        $display("  write (%0d,%0d) color %0d after stall", wr_x_out, wr_y_out, wr_color_out);
        @(negedge clk_in);
        n_cmp++;
        if (stroke_done_out !== 1'b1 || wr_valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL stall_done: got done=%b valid=%b, required done=1 valid=0", stroke_done_out, wr_valid_out);
        end
        @(negedge clk_in);
        n_cmp++;
        if (busy_out !== 1'b0) begin
            n_err++;
            $display("FAIL stall_idle: got busy=%b, required 0", busy_out);
        end
    endtask

    task automatic test_pen_up();
        run_sample(50, 50, 4, 0, 0);
        n_cmp++;
        if (got_x.size() != 0) begin
            n_err++;
            $display("FAIL penup_writes: got %0d writes, required 0", got_x.size());
        end
        run_sample(60, 50, 4, 0, 1);
        n_cmp++;
        if (got_x.size() != 1 || got_x[0] !== 60 || got_y[0] !== 50) begin
            n_err++;
            $display("FAIL penup_restamp: got %0d writes first (%0d,%0d), required 1 write (60,50)",
                     got_x.size(), got_x.size() ? got_x[0] : -1, got_y.size() ? got_y[0] : -1);
        end
    endtask

    task automatic test_brush_shape();
`ifdef STROKE_ROUND_BRUSH_EN
        int ex_x[5];
        int ex_y[5];
        ex_x = '{100, 99, 100, 101, 100};
        ex_y = '{99, 100, 100, 100, 101};
`else
        int ex_x[9];
        int ex_y[9];
        ex_x = '{99, 100, 101, 99, 100, 101, 99, 100, 101};
        ex_y = '{99, 99, 99, 100, 100, 100, 101, 101, 101};
`endif
        do_reset();
        run_sample(100, 100, 9, 1, 1);
        n_cmp++;
        if (got_x.size() != $size(ex_x)) begin
            n_err++;
            $display("FAIL brush_count: got %0d writes, required %0d", got_x.size(), $size(ex_x));
        end
        for (int i = 0; i < $size(ex_x); i++) begin
            n_cmp++;
            if (i >= got_x.size() || got_x[i] !== ex_x[i] || got_y[i] !== ex_y[i] || got_c[i] !== 9) begin
                n_err++;
                $display("FAIL brush_pt%0d: got (%0d,%0d), required (%0d,%0d)", i,
                         i < got_x.size() ? got_x[i] : -1, i < got_y.size() ? got_y[i] : -1, ex_x[i], ex_y[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int w;
        do_reset();
        wr_ready_in = 1'b0;
        pt_x_in = 10'd100; pt_y_in = 9'd100; pt_color_in = 4'd6; pt_sw_in = 3'd2; pt_pen_down_in = 1'b1;
        pt_valid_in = 1'b1;
        @(negedge clk_in);
        pt_valid_in = 1'b0;
        w = 0;
        while (!wr_valid_out && w < 50) begin @(negedge clk_in); w++; end
        n_cmp++;
        if (wr_valid_out !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_valid_timeout: got valid=%b, required 1", wr_valid_out);
        end
        rst_in = 1'b0;
        #1;
        n_cmp++;
        if ({wr_valid_out, stroke_done_out, busy_out, pt_ready_out} !== 4'b0001 ||
            wr_x_out !== 10'd0 || wr_y_out !== 9'd0 || wr_color_out !== 4'd0) begin
            n_err++;
            $display("FAIL midrst_outputs: got valid/done/busy/ready=%b%b%b%b (%0d,%0d,%0d), required 0001 (0,0,0)",
                     wr_valid_out, stroke_done_out, busy_out, pt_ready_out, wr_x_out, wr_y_out, wr_color_out);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        wr_ready_in = 1'b1;
        @(negedge clk_in);
        run_sample(102, 100, 6, 0, 1);
        n_cmp++;
        if (got_x.size() != 1 || got_x[0] !== 102 || got_y[0] !== 100) begin
            n_err++;
            $display("FAIL midrst_no_line: got %0d writes first (%0d,%0d), required 1 write (102,100)",
                     got_x.size(), got_x.size() ? got_x[0] : -1, got_y.size() ? got_y[0] : -1);
        end
    endtask

    initial begin
        test_reset();
        test_single_stamp();
        test_line();
        test_clip();
        test_backpressure();
        test_pen_up();
        test_brush_shape();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
